// File: rtl/if_id_fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for a 5-stage MIPS pipeline:
// owns the PC, resolves stall/flush/redirect priority and keeps saturating perf counters.
module if_id_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      Instr_in,
  input  logic             Branch_taken_EX,
  input  logic [31:0]      Branch_target_EX,
  input  logic             Jump_ID,
  input  logic [31:0]      Jump_target_ID,
  input  logic             MemRead_ID_EX,
  input  logic [4:0]       Rt_ID_EX,
  output logic [31:0]      PC_out,
  output logic [31:0]      IR_IF_ID_out,
  output logic [31:0]      PC_plus_4_IF_ID_out,
  output logic             Stall_out,
  output logic             Flush_ID_EX_out,
  output logic [CNT_W-1:0] Stall_count,
  output logic [CNT_W-1:0] Flush_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      ir_q, ir_d;
  logic [31:0]      pc4_q, pc4_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [31:0]      pc_inc;
  logic             hazard;

  assign pc_inc = pc_q + 32'd4;

  // Load in EX whose destination feeds either source field of the instruction in ID.
  assign hazard = MemRead_ID_EX && (Rt_ID_EX != 5'd0) &&
                  ((Rt_ID_EX == ir_q[25:21]) || (Rt_ID_EX == ir_q[20:16]));

  always_comb begin
    pc_d        = pc_inc;
    ir_d        = Instr_in;
    pc4_d       = pc_inc;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (Branch_taken_EX) begin
      pc_d  = {Branch_target_EX[31:2], 2'b00};
      ir_d  = NOP_WORD;
      pc4_d = 32'd0;
      if (flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + CNT_ONE;
    end else if (hazard) begin
      // Jump is deliberately ignored here: a jr may read the register being loaded.
      pc_d  = pc_q;
      ir_d  = ir_q;
      pc4_d = pc4_q;
      if (stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else if (Jump_ID) begin
      pc_d  = {Jump_target_ID[31:2], 2'b00};
      ir_d  = NOP_WORD;
      pc4_d = 32'd0;
      if (flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      ir_q        <= NOP_WORD;
      pc4_q       <= 32'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      pc4_q       <= pc4_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign PC_out              = pc_q;
  assign IR_IF_ID_out        = ir_q;
  assign PC_plus_4_IF_ID_out = pc4_q;
  assign Stall_out           = hazard && !Branch_taken_EX;
  assign Flush_ID_EX_out     = Branch_taken_EX;
  assign Stall_count         = stall_cnt_q;
  assign Flush_count         = flush_cnt_q;

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Directed, table-driven bench for if_id_fetch_stage; counters narrowed to 4 bits
// so saturation is reachable in a handful of cycles.
module tb_if_id_fetch_stage;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   Instr_in;
  logic          Branch_taken_EX;
  logic [31:0]   Branch_target_EX;
  logic          Jump_ID;
  logic [31:0]   Jump_target_ID;
  logic          MemRead_ID_EX;
  logic [4:0]    Rt_ID_EX;
  logic [31:0]   PC_out;
  logic [31:0]   IR_IF_ID_out;
  logic [31:0]   PC_plus_4_IF_ID_out;
  logic          Stall_out;
  logic          Flush_ID_EX_out;
  logic [CW-1:0] Stall_count;
  logic [CW-1:0] Flush_count;

  int checks = 0;
  int errors = 0;

  if_id_fetch_stage #(.RESET_PC(32'h0), .NOP_WORD(32'h0), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .Instr_in(Instr_in),
    .Branch_taken_EX(Branch_taken_EX), .Branch_target_EX(Branch_target_EX),
    .Jump_ID(Jump_ID), .Jump_target_ID(Jump_target_ID),
    .MemRead_ID_EX(MemRead_ID_EX), .Rt_ID_EX(Rt_ID_EX),
    .PC_out(PC_out), .IR_IF_ID_out(IR_IF_ID_out),
    .PC_plus_4_IF_ID_out(PC_plus_4_IF_ID_out), .Stall_out(Stall_out),
    .Flush_ID_EX_out(Flush_ID_EX_out), .Stall_count(Stall_count),
    .Flush_count(Flush_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          br;
    logic [31:0]   br_tgt;
    logic          jmp;
    logic [31:0]   jmp_tgt;
    logic          memrd;
    logic [4:0]    rt;
    logic [31:0]   instr;
    logic          e_stall;
    logic          e_flush;
    logic [31:0]   e_pc;
    logic [31:0]   e_ir;
    logic          chk_pc4;
    logic [31:0]   e_pc4;
    logic [CW-1:0] e_sc;
    logic [CW-1:0] e_fc;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(input logic br, input logic [31:0] br_tgt,
                              input logic jmp, input logic [31:0] jmp_tgt,
                              input logic memrd, input logic [4:0] rt,
                              input logic [31:0] instr, input logic e_stall,
                              input logic e_flush, input logic [31:0] e_pc,
                              input logic [31:0] e_ir, input logic chk_pc4,
                              input logic [31:0] e_pc4, input logic [CW-1:0] e_sc,
                              input logic [CW-1:0] e_fc);
    vec_t v;
    v.br = br; v.br_tgt = br_tgt; v.jmp = jmp; v.jmp_tgt = jmp_tgt;
    v.memrd = memrd; v.rt = rt; v.instr = instr;
    v.e_stall = e_stall; v.e_flush = e_flush; v.e_pc = e_pc; v.e_ir = e_ir;
    v.chk_pc4 = chk_pc4; v.e_pc4 = e_pc4; v.e_sc = e_sc; v.e_fc = e_fc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic br, input logic [31:0] br_tgt, input logic jmp,
                       input logic [31:0] jmp_tgt, input logic memrd,
                       input logic [4:0] rt, input logic [31:0] instr);
    Branch_taken_EX  = br;
    Branch_target_EX = br_tgt;
    Jump_ID          = jmp;
    Jump_target_ID   = jmp_tgt;
    MemRead_ID_EX    = memrd;
    Rt_ID_EX         = rt;
    Instr_in         = instr;
  endtask

  task automatic chk_regs(input string tag, input logic [31:0] pc, input logic [31:0] ir,
                          input logic chk_pc4, input logic [31:0] pc4,
                          input logic [CW-1:0] sc, input logic [CW-1:0] fc);
    chk({tag, " pc"}, PC_out, pc);
    chk({tag, " ir"}, IR_IF_ID_out, ir);
    if (chk_pc4) chk({tag, " pc4"}, PC_plus_4_IF_ID_out, pc4);
    chk({tag, " stall_cnt"}, 32'(Stall_count), 32'(sc));
    chk({tag, " flush_cnt"}, 32'(Flush_count), 32'(fc));
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    // Reset overrides inputs, so apply it with a busy input pattern.
    @(negedge clk);
    drive(1'b1, 32'h500, 1'b1, 32'h600, 1'b1, 5'd3, 32'hFFFF_FFFF);
    @(posedge clk); @(posedge clk); #1;
    chk_regs("reset", 32'h0, 32'h0, 1'b1, 32'h0, 4'd0, 4'd0);
    $display("txn reset pc=%08h ir=%08h", PC_out, IR_IF_ID_out);

    //            br tgt     jmp tgt          mr rt  instr          st fl pc            ir            c4 pc4           sc fc
    vecs[0]  = mk(0, 32'h0,   0, 32'h0,        0, 0, 32'h20080001, 0, 0, 32'h4,        32'h20080001, 1, 32'h4,        0, 0);
    vecs[1]  = mk(0, 32'h0,   0, 32'h0,        0, 0, 32'h20080001, 0, 0, 32'h8,        32'h20080001, 1, 32'h8,        0, 0);
    vecs[2]  = mk(0, 32'h0,   0, 32'h0,        0, 0, 32'h20080001, 0, 0, 32'hC,        32'h20080001, 1, 32'hC,        0, 0);
    vecs[3]  = mk(0, 32'h0,   0, 32'h0,        0, 0, 32'h01095020, 0, 0, 32'h10,       32'h01095020, 1, 32'h10,       0, 0);
    vecs[4]  = mk(0, 32'h0,   0, 32'h0,        1, 8, 32'hAAAA5555, 1, 0, 32'h10,       32'h01095020, 1, 32'h10,       1, 0);
    vecs[5]  = mk(0, 32'h0,   0, 32'h0,        0, 8, 32'h00000020, 0, 0, 32'h14,       32'h00000020, 1, 32'h14,       1, 0);
    vecs[6]  = mk(0, 32'h0,   0, 32'h0,        1, 0, 32'h01284020, 0, 0, 32'h18,       32'h01284020, 1, 32'h18,       1, 0);
    vecs[7]  = mk(0, 32'h0,   1, 32'h80,       1, 8, 32'h11111111, 1, 0, 32'h18,       32'h01284020, 1, 32'h18,       2, 0);
    vecs[8]  = mk(1, 32'h103, 1, 32'h40,       1, 8, 32'h22222222, 0, 1, 32'h100,      32'h0,        1, 32'h0,        2, 1);
    vecs[9]  = mk(0, 32'h0,   1, 32'h40,       0, 0, 32'h12345678, 0, 0, 32'h40,       32'h0,        0, 32'h0,        2, 2);
    vecs[10] = mk(0, 32'h0,   0, 32'h0,        0, 0, 32'h12345678, 0, 0, 32'h44,       32'h12345678, 1, 32'h44,       2, 2);
    vecs[11] = mk(0, 32'h0,   1, 32'hFFFFFFFF, 0, 0, 32'h33333333, 0, 0, 32'hFFFFFFFC, 32'h0,        0, 32'h0,        2, 3);
    vecs[12] = mk(0, 32'h0,   0, 32'h0,        0, 0, 32'h00000020, 0, 0, 32'h0,        32'h00000020, 1, 32'h0,        2, 3);
    vecs[13] = mk(1, 32'h202, 0, 32'h0,        0, 0, 32'h44444444, 0, 1, 32'h200,      32'h0,        1, 32'h0,        2, 4);

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      reset = 1'b0;
      drive(vecs[i].br, vecs[i].br_tgt, vecs[i].jmp, vecs[i].jmp_tgt,
            vecs[i].memrd, vecs[i].rt, vecs[i].instr);
      #1;
      chk($sformatf("v%0d stall", i), 32'(Stall_out), 32'(vecs[i].e_stall));
      chk($sformatf("v%0d flush", i), 32'(Flush_ID_EX_out), 32'(vecs[i].e_flush));
      @(posedge clk); #1;
      chk_regs($sformatf("v%0d", i), vecs[i].e_pc, vecs[i].e_ir, vecs[i].chk_pc4,
               vecs[i].e_pc4, vecs[i].e_sc, vecs[i].e_fc);
      $display("txn v%0d pc=%08h ir=%08h pc4=%08h sc=%0d fc=%0d", i, PC_out,
               IR_IF_ID_out, PC_plus_4_IF_ID_out, Stall_count, Flush_count);
    end

    // Stall-count saturation: load IR with rs=8, then hold the hazard 15 cycles (2+15 > 15).
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 32'h01095020);
    @(posedge clk); #1;
    chk_regs("sat_pre", 32'h204, 32'h01095020, 1'b1, 32'h204, 4'd2, 4'd4);
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 5'd8, 32'h55555555);
      @(posedge clk);
    end
    #1;
    chk_regs("stall_sat", 32'h204, 32'h01095020, 1'b1, 32'h204, 4'd15, 4'd4);
    $display("txn stall_sat sc=%0d", Stall_count);

    // Flush-count saturation via 12 jumps (4+12 > 15).
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      drive(1'b0, 32'h0, 1'b1, 32'h300 + 32'(k * 16), 1'b0, 5'd0, 32'h0);
      @(posedge clk);
    end
    #1;
    chk_regs("flush_sat", 32'h3B0, 32'h0, 1'b0, 32'h0, 4'd15, 4'd15);
    $display("txn flush_sat fc=%0d pc=%08h", Flush_count, PC_out);

    // Reset in the middle of a stall, with a branch also pending.
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 32'h01095020);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 5'd8, 32'h0);
    #1;
    chk("midstall stall_on", 32'(Stall_out), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 32'h700, 1'b1, 32'h800, 1'b1, 5'd8, 32'h66666666);
    @(posedge clk); #1;
    chk_regs("midstall_reset", 32'h0, 32'h0, 1'b1, 32'h0, 4'd0, 4'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 5'd8, 32'h0);
    #1;
    chk("post_reset stall", 32'(Stall_out), 32'd0);
    $display("txn midstall_reset pc=%08h ir=%08h stall=%0d", PC_out, IR_IF_ID_out, Stall_out);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
